seq_cmp: RTL and testbench
==========================

# seq_cmp

Parametrised multi-cycle magnitude comparator for the pipelined CPU datapath, successor to the single-cycle 32-bit unsigned greater-than unit. It scans operands MSB-first, one DIGIT-bit slice per cycle, exits early on the first differing slice, and supports signed/unsigned operands and six relational operations. A start/ready/done handshake lets the EX stage stall on it, like the other multi-cycle units.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of DIGIT.
- DIGIT, 4: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only on an edge where ready=1.
- a  in  WIDTH  left operand, sampled with start.
- b  in  WIDTH  right operand, sampled with start.
- op  in  3  000 EQ, 001 NE, 010 LT, 011 GE, 100 GT, 101 LE, 11x reserved.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- ready  out  1  high in IDLE only.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse; d is valid from this cycle on.
- d  out  WIDTH  result, zero-extended: 1 if relation holds, else 0.

## Operation
- States: IDLE, SCAN, DONE. Reset → IDLE, ready=1, busy=0, done=0, d=0, slice counter=0.
- IDLE: on start=1, capture a, b, op; if is_signed, invert bit WIDTH-1 of both captured operands (offset-binary mapping) so the rest of the scan is purely unsigned. Load counter k=0 → SCAN.
- SCAN: compare slice k (bits WIDTH-1-k·DIGIT down to WIDTH-(k+1)·DIGIT) of the captured operands.
  - Slices differ: latch gt/lt flag → DONE.
  - Slices equal and k = WIDTH/DIGIT−1: latch eq → DONE.
  - Otherwise k ← k+1, stay in SCAN.
- DONE: d ← {0…0, rel}, where rel comes from op and the latched flag. EQ=eq, NE=!eq, LT=lt, GE=!lt, GT=gt, LE=!gt. Reserved op gives rel=0. done=1 for this one cycle → IDLE.
- d holds its value until the next DONE or reset. It never changes during SCAN.
- start with ready=0 is ignored, with no queuing. Operand inputs are don't-care except on the accept edge.
- Reset asserted in any state forces the reset values immediately. Any in-flight compare is discarded with no done pulse.

## Timing
- Accept at edge T. Let k* be the deciding slice (k* = WIDTH/DIGIT−1 if operands are equal).
- SCAN runs from edge T through edge T+k*+1. d updates and done=1 from edge T+k*+2 for one cycle. ready=1 again from edge T+k*+3.
- With defaults: best case done at T+2, worst case at T+9.
- Throughput is one compare per k*+3 cycles. start held high re-issues on the first ready edge.
- Output d is registered. No combinational path from inputs to outputs except none; ready, busy and done are decoded from state registers.

## Structure
- Package cmp_pkg holds:
  - op encodings: OP_EQ, OP_NE, OP_LT, OP_GE, OP_GT, OP_LE
  - the state enum: ST_IDLE, ST_SCAN, ST_DONE
- Sub-module digit_cmp (parameter DIGIT) is a purely combinational DIGIT-bit unsigned compare with outputs gt and lt. seq_cmp instantiates it once, fed by a slice mux indexed by k.
- The top level holds the FSM, counter, operand registers, flag latch and result register.

## Test plan
- Unsigned GT, WIDTH=32, DIGIT=4: a=5, b=3, op=GT → only slice 7 differs; done at T+9; d=1. Same with op=LE → d=0.
- Signed LT: a=0xFFFFFFFF, b=1, is_signed=1, op=LT → slice 0 decides; done at T+2; d=1. Same with is_signed=0 → d=0.
- Equality: a=b=0x12345678, op=EQ → done at T+9, d=1. With op=NE → d=0. With op=110 → d=0.
- start pulsed at T+1..T+4 during a busy compare → ignored; exactly one done pulse; d reflects the first request only.
- Reset asserted at T+3 mid-SCAN → immediately ready=1, busy=0, d=0; no done pulse. A new compare after release completes normally.
- WIDTH=8, DIGIT=1: a=0x80, b=0x7F, is_signed=1, op=GT → d=0 at T+2. With is_signed=0 → d=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared encodings for the sequential magnitude comparator: relational op codes,
// FSM states and the op-to-relation decode.
package cmp_pkg;

  localparam logic [2:0] OP_EQ = 3'b000;
  localparam logic [2:0] OP_NE = 3'b001;
  localparam logic [2:0] OP_LT = 3'b010;
  localparam logic [2:0] OP_GE = 3'b011;
  localparam logic [2:0] OP_GT = 3'b100;
  localparam logic [2:0] OP_LE = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Reserved op codes (11x) always yield a false relation.
  function automatic logic rel_of(input logic [2:0] op, input logic gt, input logic lt);
    logic rel;
    case (op)
      OP_EQ:   rel = !(gt || lt);
      OP_NE:   rel = gt || lt;
      OP_LT:   rel = lt;
      OP_GE:   rel = !lt;
      OP_GT:   rel = gt;
      OP_LE:   rel = !gt;
      default: rel = 1'b0;
    endcase
    return rel;
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Purely combinational unsigned compare of one DIGIT-bit slice.
module digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x_i,
  input  logic [DIGIT-1:0] y_i,
  output logic             gt_o,
  output logic             lt_o
);

  assign gt_o = (x_i > y_i);
  assign lt_o = (x_i < y_i);

endmodule

// File: rtl/seq_cmp.sv
// Multi-cycle MSB-first magnitude comparator: one DIGIT-bit slice per cycle,
// early exit on the first differing slice, signed/unsigned, six relations.
module seq_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             is_signed_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o
);

  localparam int NSL = WIDTH / DIGIT;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] d_q;

  logic [31:0]      lo_s;
  logic [DIGIT-1:0] a_sl_s;
  logic [DIGIT-1:0] b_sl_s;
  logic             gt_s;
  logic             lt_s;
  logic             last_s;

  // Slice k sits at bits WIDTH-1-k*DIGIT down to WIDTH-(k+1)*DIGIT.
  assign lo_s   = 32'(WIDTH - DIGIT) - (32'(k_q) * 32'(DIGIT));
  assign a_sl_s = a_q[lo_s +: DIGIT];
  assign b_sl_s = b_q[lo_s +: DIGIT];
  assign last_s = (k_q == KW'(NSL - 1));

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .x_i  (a_sl_s),
    .y_i  (b_sl_s),
    .gt_o (gt_s),
    .lt_o (lt_s)
  );

  // Flipping the sign bit maps two's complement onto offset binary, so the scan stays unsigned.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'b000;
      d_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            a_q     <= is_signed_i ? (a_i ^ SIGN_BIT) : a_i;
            b_q     <= is_signed_i ? (b_i ^ SIGN_BIT) : b_i;
            op_q    <= op_i;
            k_q     <= '0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (gt_s || lt_s || last_s) begin
            d_q     <= WIDTH'(rel_of(op_q, gt_s, lt_s));
            state_q <= ST_DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign busy_o  = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign done_o  = (state_q == ST_DONE);
  assign d_o     = d_q;

endmodule

// File: tb/tb_seq_cmp.sv
// Self-checking bench for seq_cmp: directed table, random compares against an
// arithmetic reference model, and hand-written handshake/reset sequences.
module tb_seq_cmp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st32 = 1'b0, st8 = 1'b0;
  logic [31:0] a32 = 32'd0, b32 = 32'd0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic [2:0]  op = 3'b000;
  logic        sgn = 1'b0;
  logic        rdy32, bsy32, dn32, rdy8, bsy8, dn8;
  logic [31:0] d32;
  logic [7:0]  d8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_cmp #(.WIDTH(32), .DIGIT(4)) u_dut (
    .clock_i(clk), .reset_i(rst), .start_i(st32), .a_i(a32), .b_i(b32),
    .op_i(op), .is_signed_i(sgn), .ready_o(rdy32), .busy_o(bsy32),
    .done_o(dn32), .d_o(d32)
  );

  seq_cmp #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clock_i(clk), .reset_i(rst), .start_i(st8), .a_i(a8), .b_i(b8),
    .op_i(op), .is_signed_i(sgn), .ready_o(rdy8), .busy_o(bsy8),
    .done_o(dn8), .d_o(d8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // lat = edges after the accept edge until done is seen high; spec "done at T+n" means lat = n-1.
  task automatic run(input bit w8, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] o, input logic s,
                     output logic [31:0] d, output int lat);
    int n;
    n = 0;
    while (!(w8 ? rdy8 : rdy32) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (w8) begin a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; end
    else    begin a32 = a; b32 = b; st32 = 1'b1; end
    op = o; sgn = s;
    @(posedge clk); #1;
    st8 = 1'b0; st32 = 1'b0;
    a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    op = 3'($urandom); sgn = 1'($urandom);
    lat = 0;
    while (!(w8 ? dn8 : dn32) && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    d = w8 ? {24'd0, d8} : d32;
  endtask

  // Reference: relation from signed/unsigned integer arithmetic, latency from the top differing bit.
  function automatic void model(input int w, input int dg, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] o, input logic s, output logic rel, output int lat);
    longint va, vb;
    logic [31:0] x;
    int p;
    va = longint'(a);
    vb = longint'(b);
    if (s && va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
    if (s && vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
    x = a ^ b;
    p = -1;
    for (int i = 0; i < w; i++) if (x[i]) p = i;
    lat = (p < 0) ? (w / dg) : ((w - 1 - p) / dg + 1);
    case (o)
      3'd0:    rel = (va == vb);
      3'd1:    rel = (va != vb);
      3'd2:    rel = (va <  vb);
      3'd3:    rel = (va >= vb);
      3'd4:    rel = (va >  vb);
      3'd5:    rel = (va <= vb);
      default: rel = 1'b0;
    endcase
  endfunction

  typedef struct {
    bit          w8;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        s;
    logic [31:0] d;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] d;
    logic        rel;
    int          lat, elat, cnt, n;
    bit          w8;
    logic [31:0] a, b;
    logic [2:0]  o;
    logic        s;

    tbl[0]  = '{1'b0, 32'd5,          32'd3,          3'b100, 1'b0, 32'd1, 8};
    tbl[1]  = '{1'b0, 32'd5,          32'd3,          3'b101, 1'b0, 32'd0, 8};
    tbl[2]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          3'b010, 1'b1, 32'd1, 1};
    tbl[3]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          3'b010, 1'b0, 32'd0, 1};
    tbl[4]  = '{1'b0, 32'h1234_5678,  32'h1234_5678,  3'b000, 1'b0, 32'd1, 8};
    tbl[5]  = '{1'b0, 32'h1234_5678,  32'h1234_5678,  3'b001, 1'b0, 32'd0, 8};
    tbl[6]  = '{1'b0, 32'h1234_5678,  32'h1234_5678,  3'b110, 1'b0, 32'd0, 8};
    tbl[7]  = '{1'b0, 32'd0,          32'd1,          3'b111, 1'b0, 32'd0, 8};
    tbl[8]  = '{1'b0, 32'h8000_0000,  32'h7FFF_FFFF,  3'b011, 1'b1, 32'd0, 1};
    tbl[9]  = '{1'b0, 32'h1000_0000,  32'h2000_0000,  3'b010, 1'b0, 32'd1, 1};
    tbl[10] = '{1'b1, 32'h80,         32'h7F,         3'b100, 1'b1, 32'd0, 1};
    tbl[11] = '{1'b1, 32'h80,         32'h7F,         3'b100, 1'b0, 32'd1, 1};

    @(posedge clk); @(posedge clk); #1;
    chk("reset_ready", {31'd0, rdy32}, 32'd1);
    chk("reset_busy",  {31'd0, bsy32}, 32'd0);
    chk("reset_done",  {31'd0, dn32},  32'd0);
    chk("reset_d",     d32,            32'd0);
    chk("reset_d8",    {24'd0, d8},    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run(tbl[i].w8, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].s, d, lat);
      chk($sformatf("tbl%0d_d", i), d, tbl[i].d);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    for (int i = 0; i < 60; i++) begin
      w8 = 1'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'd1 << $urandom_range(0, 31));
        2:       b = a ^ (32'd1 << $urandom_range(0, 7));
        default: b = $urandom;
      endcase
      if (w8) begin a = a & 32'hFF; b = b & 32'hFF; end
      o = 3'($urandom);
      s = 1'($urandom);
      model(w8 ? 8 : 32, w8 ? 1 : 4, a, b, o, s, rel, elat);
      run(w8, a, b, o, s, d, lat);
      chk($sformatf("rnd%0d_d", i), d, {31'd0, rel});
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
    end

    // start re-pulsed while busy must be ignored: one done, result of the first request.
    n = 0;
    while (!rdy32 && n < 50) begin @(posedge clk); #1; n++; end
    a32 = 32'd5; b32 = 32'd3; op = 3'b100; sgn = 1'b0; st32 = 1'b1;
    @(posedge clk); #1;
    a32 = 32'd3; b32 = 32'd5;
    cnt = 0; d = 32'hDEAD_BEEF;
    for (int i = 0; i < 14; i++) begin
      if (i == 4) st32 = 1'b0;
      @(posedge clk); #1;
      if (dn32) begin cnt++; d = d32; end
    end
    chk("busy_start_pulses", 32'(cnt), 32'd1);
    chk("busy_start_d", d, 32'd1);

    // start held high: equal operands give one compare every 8+3 - 1 = 10 cycles... k*=7 so k*+3 = 10.
    a32 = 32'hCAFE_F00D; b32 = 32'hCAFE_F00D; op = 3'b000; sgn = 1'b0; st32 = 1'b1;
    n = 0;
    while (!dn32 && n < 60) begin @(posedge clk); #1; n++; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!dn32 && n < 60);
    st32 = 1'b0;
    chk("throughput_cycles", 32'(n), 32'd10);
    chk("throughput_d", d32, 32'd1);

    // Reset mid-SCAN: immediate return to idle values, in-flight compare dropped.
    n = 0;
    while (!rdy32 && n < 50) begin @(posedge clk); #1; n++; end
    a32 = 32'd5; b32 = 32'd3; op = 3'b100; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, rdy32}, 32'd1);
    chk("midrst_busy",  {31'd0, bsy32}, 32'd0);
    chk("midrst_d",     d32,            32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dn32) cnt++;
    end
    chk("midrst_no_done", 32'(cnt), 32'd0);
    run(1'b0, 32'hFFFF_FFF0, 32'h0000_0010, 3'b100, 1'b1, d, lat);
    chk("post_rst_d", d, 32'd0);
    chk("post_rst_lat", 32'(lat), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
